nrdiv: RTL and testbench
========================

# nrdiv

Newton-Raphson reciprocal/divide datapath computing Q ≈ X / D in 8-bit unsigned fixed point. It contains one shared multiplier, a reciprocal seed ROM, two working registers (A and B) and operand multiplexers. An external controller sequences it by driving mux selects and register load enables every cycle; the block itself has no state machine. Higher-level arithmetic units use it as the iterative divider core.

## Interface
- Parameters: none. All data paths are fixed at 8 bits.
- Positional port order: Q, rega_out, regb_out, D, X, sel_muxd, sel_muxa, sel_muxb, load_rega, load_regb, Clk, Rst_n.
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  one clock; reset is synchronous and active-low.
- D  input  8  divisor, U1.7 (value = code/128).
- X  input  8  dividend, U1.7.
- sel_muxd  input  1  1 selects D, 0 selects X as the external multiplier operand.
- sel_muxa  input  1  operand-1 select: 1 selects seed ROM, 0 selects register A.
- sel_muxb  input  1  operand-2 select: 1 selects register B, 0 selects the muxd output. Also steers register A's input.
- load_rega  input  1  load enable for register A.
- load_regb  input  1  load enable for register B.
- Q  output  8  combinational multiplier result P, U1.7.
- rega_out  output  8  register A contents.
- regb_out  output  8  register B contents.

## Operation
- Seed:
  - Index m = {D[7:4], 4'b1000}.
  - seed = floor(16384 / m), saturated to 0xFF. Implement as a 16-entry ROM on D[7:4].
  - Example: D[7:4]=4'h8 → 0x78; 4'hC → 0x51; 4'h5 → 0xBA.
- Operand and product paths:
  - muxd = sel_muxd ? D : X.
  - op1 = sel_muxa ? seed : rega_out.
  - op2 = sel_muxb ? regb_out : muxd.
  - P = (op1 × op2)[14:7]: 16-bit unsigned product, truncated, bit 15 discarded.
  - Q = P.
- Register inputs:
  - A_next = sel_muxb ? P : op1.
  - B_next = (~P + 1) mod 256, which is 2 − P in U1.7 with wrap (P=0 gives 0x00).
- Register update on rising Clk:
  - Rst_n=0: A and B load 0x00. Reset wins over the load enables.
  - Otherwise each register loads its input only when its own enable is 1, else holds.
  - Both registers may load in the same cycle.
- Controller sequence, as (sel_muxa, sel_muxb, sel_muxd) → load:
  - S1 (1,0,1) → load A and B: A = R0 = seed, B = T0 = 2 − D·R0.
  - S2 (1,1,1) → load A: A = R1 = seed·T0. D must be unchanged since S1.
  - S3 (0,0,1) → load B: B = T1 = 2 − D·R1.
  - S4 (0,1,1) → load A: A = R2 = R1·T1.
  - S3/S4 repeat for further iterations.
  - Final: (0,0,0), no loads. Q = R·X is the quotient.
- No rounding or saturation except the seed. Overflow wraps.
- Unnormalized D (D[7]=0) is legal. The seed saturates, and the result is the arithmetic defined above with no error flag.

## Timing
- Q is purely combinational from D, X, the selects and the registers: zero-cycle latency.
- A register load is visible on rega_out/regb_out immediately after the rising edge.
- Selects and data must be stable for setup before each rising edge. Load enables are sampled only at the edge.
- Reset asserted mid-sequence clears both registers on the next edge. The sequence must restart at S1.
- After reset: rega_out = regb_out = 0x00. Q = P of the current selects (e.g. 0x00 when sel_muxa=0).

## Test plan
- Reset: Rst_n=0 for one edge with both loads high → rega_out=regb_out=0x00. Then with sel_muxa=0 and sel_muxb=0, Q=0x00.
- D=0x80, sequence S1,S2,S3,S4:
  - S1 → A=0x78, B=0x88.
  - S2 → A=0x7F.
  - S3 → B=0x81.
  - S4 → A=0x7F.
  - Final with X=0xC0 → Q=0xBE.
- D=0xC0, same sequence:
  - S1 → A=0x51, B=0x87.
  - S2 → A=0x55.
  - S3 → B=0x81.
  - S4 → A=0x55.
  - Final with X=0x80 → Q=0x55.
- Hold: load_rega=load_regb=0 for 3 edges with changing selects → registers unchanged, while Q tracks the selects combinationally.
- Wrap and saturation:
  - D=0x50 → seed 0xBA.
  - D=0x10 → seed 0xFF.
  - P=0x00 → B loads 0x00.
- Mid-sequence reset after S2 → both registers 0x00. Rerunning from S1 reproduces the results of scenario 2.

Source files
------------

// File: rtl/nrdiv.sv
// nrdiv: Newton-Raphson reciprocal/divide datapath, 8-bit U1.7 fixed point.
// One shared multiplier, a 16-entry reciprocal seed ROM indexed by D[7:4],
// and two working registers (A, B). An external controller drives the
// operand selects and load enables every cycle; there is no internal FSM.
module nrdiv (
  output logic [7:0] Q,
  output logic [7:0] rega_out,
  output logic [7:0] regb_out,
  input  logic [7:0] D,
  input  logic [7:0] X,
  input  logic       sel_muxd,
  input  logic       sel_muxa,
  input  logic       sel_muxb,
  input  logic       load_rega,
  input  logic       load_regb,
  input  logic       Clk,
  input  logic       Rst_n
);

  logic [7:0]  seed;
  logic [7:0]  muxd;
  logic [7:0]  op1;
  logic [7:0]  op2;
  logic [15:0] prod;
  logic [7:0]  p;
  logic [7:0]  rega_q, rega_d;
  logic [7:0]  regb_q, regb_d;

  // Seed ROM: floor(16384 / {D[7:4],4'b1000}), saturated to 0xFF
  always_comb begin
    seed = 8'hFF;
    unique case (D[7:4])
      4'h0:    seed = 8'hFF;
      4'h1:    seed = 8'hFF;
      4'h2:    seed = 8'hFF;
      4'h3:    seed = 8'hFF;
      4'h4:    seed = 8'hE3;
      4'h5:    seed = 8'hBA;
      4'h6:    seed = 8'h9D;
      4'h7:    seed = 8'h88;
      4'h8:    seed = 8'h78;
      4'h9:    seed = 8'h6B;
      4'hA:    seed = 8'h61;
      4'hB:    seed = 8'h59;
      4'hC:    seed = 8'h51;
      4'hD:    seed = 8'h4B;
      4'hE:    seed = 8'h46;
      4'hF:    seed = 8'h42;
      default: seed = 8'hFF;
    endcase
  end

  // Operand muxes and shared multiplier; product truncated to U1.7, bit 15 dropped
  always_comb begin
    muxd = sel_muxd ? D : X;
    op1  = sel_muxa ? seed : rega_q;
    op2  = sel_muxb ? regb_q : muxd;
    prod = 16'(op1) * 16'(op2);
    p    = prod[14:7];
  end

  // Register next-state: A takes the product when sel_muxb is set, else op1;
  // B always takes the two's complement of the product (2 - P in U1.7)
  always_comb begin
    rega_d = rega_q;
    regb_d = regb_q;
    if (load_rega) rega_d = sel_muxb ? p : op1;
    if (load_regb) regb_d = 8'(~p + 8'd1);
  end

  // Working registers with synchronous active-low reset overriding loads
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rega_q <= '0;
      regb_q <= '0;
    end else begin
      rega_q <= rega_d;
      regb_q <= regb_d;
    end
  end

  assign Q        = p;
  assign rega_out = rega_q;
  assign regb_out = regb_q;

endmodule

// File: tb/tb_nrdiv.sv
// tb_nrdiv: directed self-checking bench for nrdiv with hand-computed values.
module tb_nrdiv;

  logic [7:0] Q, rega_out, regb_out, D, X;
  logic       sel_muxd, sel_muxa, sel_muxb, load_rega, load_regb;
  logic       Clk, Rst_n;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  nrdiv dut (
    .Q         (Q),
    .rega_out  (rega_out),
    .regb_out  (regb_out),
    .D         (D),
    .X         (X),
    .sel_muxd  (sel_muxd),
    .sel_muxa  (sel_muxa),
    .sel_muxb  (sel_muxb),
    .load_rega (load_rega),
    .load_regb (load_regb),
    .Clk       (Clk),
    .Rst_n     (Rst_n)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Apply selects/loads away from the edge, then clock once and settle
  task automatic step(input logic sa, input logic sb, input logic sd,
                      input logic la, input logic lb);
    @(negedge Clk);
    sel_muxa  = sa;
    sel_muxb  = sb;
    sel_muxd  = sd;
    load_rega = la;
    load_regb = lb;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_sel(input logic sa, input logic sb, input logic sd);
    sel_muxa = sa;
    sel_muxb = sb;
    sel_muxd = sd;
    #1;
  endtask

  initial begin
    D = 8'h80; X = 8'h00;
    sel_muxa = 1'b1; sel_muxb = 1'b0; sel_muxd = 1'b1;
    load_rega = 1'b1; load_regb = 1'b1;
    Rst_n = 1'b0;

    // Reset wins over both load enables
    @(posedge Clk); #1;
    chk("rst_a", rega_out, 8'h00);
    chk("rst_b", regb_out, 8'h00);
    @(negedge Clk);
    set_sel(1'b0, 1'b0, 1'b1);
    chk("rst_q", Q, 8'h00);
    Rst_n = 1'b1;

    // Scenario D=0x80
    @(negedge Clk); D = 8'h80; X = 8'hC0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("d80_s1_a", rega_out, 8'h78);
    chk("d80_s1_b", regb_out, 8'h88);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("d80_s2_a", rega_out, 8'h7F);
    chk("d80_s2_b", regb_out, 8'h88);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("d80_s3_b", regb_out, 8'h81);
    chk("d80_s3_a", rega_out, 8'h7F);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("d80_s4_a", rega_out, 8'h7F);
    @(negedge Clk);
    set_sel(1'b0, 1'b0, 1'b0);
    chk("d80_final_q", Q, 8'hBE);

    // Hold: three edges without loads, Q follows selects combinationally
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hold1_q", Q, 8'h78);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold2_q", Q, 8'h7F);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold3_q", Q, 8'h78);
    chk("hold_a", rega_out, 8'h7F);
    chk("hold_b", regb_out, 8'h81);

    // Scenario D=0xC0
    @(negedge Clk); D = 8'hC0; X = 8'h80;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("dc0_s1_a", rega_out, 8'h51);
    chk("dc0_s1_b", regb_out, 8'h87);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("dc0_s2_a", rega_out, 8'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("dc0_s3_b", regb_out, 8'h81);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("dc0_s4_a", rega_out, 8'h55);
    @(negedge Clk);
    set_sel(1'b0, 1'b0, 1'b0);
    chk("dc0_final_q", Q, 8'h55);

    // Seed ROM: unnormalised D saturates; multiplier keeps bits [14:7] only
    @(negedge Clk); D = 8'h50;
    set_sel(1'b1, 1'b0, 1'b1);
    chk("d50_q", Q, 8'h74);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("seed_d50", rega_out, 8'hBA);
    @(negedge Clk); D = 8'h10;
    set_sel(1'b1, 1'b0, 1'b1);
    chk("d10_q", Q, 8'h1F);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("seed_d10", rega_out, 8'hFF);
    @(negedge Clk); X = 8'hFF;
    set_sel(1'b0, 1'b0, 1'b0);
    chk("wrap_q", Q, 8'hFC);

    // P=0 makes B load 0x00 (B was 0x81)
    @(negedge Clk); D = 8'h00;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("p0_b", regb_out, 8'h00);

    // Mid-sequence reset after S2, then rerun D=0xC0 from S1
    @(negedge Clk); D = 8'hC0; X = 8'h80;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge Clk); Rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("mrst_a", rega_out, 8'h00);
    chk("mrst_b", regb_out, 8'h00);
    @(negedge Clk); Rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("re_s1_a", rega_out, 8'h51);
    chk("re_s1_b", regb_out, 8'h87);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("re_s2_a", rega_out, 8'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("re_s3_b", regb_out, 8'h81);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("re_s4_a", rega_out, 8'h55);
    @(negedge Clk);
    set_sel(1'b0, 1'b0, 1'b0);
    chk("re_final_q", Q, 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
